// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus decode constants and target classes.
package z80_bus_pkg;

    localparam int unsigned WINDOW_BITS = 14;

    localparam logic [7:0] UART_BASE = 8'h70;
    localparam logic [7:0] DEC_BASE  = 8'h74;
    localparam logic [7:0] PAGE_BASE = 8'h78;
    localparam logic [7:0] STATUS    = 8'h7D;
    localparam logic [7:0] CTRL      = 8'h7E;
    localparam logic [7:0] BANK      = 8'h7F;

    typedef enum logic [2:0] {
        T_RAM,
        T_ROM,
        T_UART,
        T_DEC,
        T_IO,
        T_NONE
    } target_e;

endpackage

// File: rtl/z80_wait_gen.sv
// Z80 WAIT generator: loads a wait count on each request start and counts it down.
module z80_wait_gen #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req,
    input  logic [CNT_W-1:0] load,
    output logic             wait_n
);

    logic             req_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A dropped request abandons the remaining wait count.
    always_comb begin
        cnt_d = cnt_q;
        if (req && !req_q) begin
            cnt_d = load;
        end else if (!req) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            req_q <= req;
            cnt_q <= cnt_d;
        end
    end

    assign wait_n = (cnt_q == '0);

endmodule

// File: rtl/z80_bank_decoder.sv
// Z80 memory/IO decoder with four paged 16 KB windows, banked IO selects,
// per-target wait states and edge-triggered internal register writes.
module z80_bank_decoder #(
    parameter int unsigned PHYS_ADDR_W = 20,
    parameter int unsigned NUM_IO_CH   = 8,
    parameter int unsigned ROM_WAIT    = 1,
    parameter int unsigned IO_WAIT     = 2,
    parameter int unsigned UART_WAIT   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [15:0]            addr_i,
    input  logic [7:0]             data_i,
    input  logic                   wr_n,
    input  logic                   rd_n,
    input  logic                   mreq_n,
    input  logic                   ioreq_n,
    output logic [7:0]             data_o,
    output logic [PHYS_ADDR_W-1:0] phys_addr_o,
    output logic                   ram_cs,
    output logic                   rom_cs,
    output logic                   uart_cs,
    output logic                   dec_cs,
    output logic [NUM_IO_CH-1:0]   io_cs,
    output logic                   wait_n
);

    import z80_bus_pkg::*;

    localparam int unsigned PAGE_W = PHYS_ADDR_W - WINDOW_BITS;
    localparam int unsigned WAIT_W = 8;

    logic [PAGE_W-1:0] page_q [4];
    logic              rom_dis_q;
    logic              bad_bank_q;
    logic [7:0]        io_bank_q;
    logic              wr_act_q;
    logic              st_rd_q;

    logic [7:0]        port;
    logic              io_req;
    logic              mem_req;
    logic              is_uart;
    logic              is_dec;
    logic              is_page;
    logic              bank_ok;
    logic              wr_act;
    logic              wr_stb;
    logic              st_rd;
    logic [WAIT_W-1:0] wait_load;
    target_e           target;

    assign port    = addr_i[7:0];
    assign io_req  = !ioreq_n;
    assign mem_req = !mreq_n;
    assign is_uart = (port[7:2] == UART_BASE[7:2]);
    assign is_dec  = (port[7:4] == DEC_BASE[7:4]) && (port[3:2] != 2'b00);
    assign is_page = (port[7:2] == PAGE_BASE[7:2]);
    assign bank_ok = (32'(io_bank_q) < NUM_IO_CH);

    // IO decode takes priority over a simultaneous (illegal) memory request.
    always_comb begin
        target = T_NONE;
        if (io_req) begin
            if (is_uart) begin
                target = T_UART;
            end else if (is_dec) begin
                target = T_DEC;
            end else if (bank_ok) begin
                target = T_IO;
            end
        end else if (mem_req) begin
            if (addr_i[15:14] == 2'b00 && !rom_dis_q) begin
                target = T_ROM;
            end else begin
                target = T_RAM;
            end
        end
    end

    assign ram_cs  = (target == T_RAM);
    assign rom_cs  = (target == T_ROM);
    assign uart_cs = (target == T_UART);
    assign dec_cs  = (target == T_DEC);

    always_comb begin
        io_cs = '0;
        for (int unsigned i = 0; i < NUM_IO_CH; i++) begin
            if (target == T_IO && io_bank_q == 8'(i)) begin
                io_cs[i] = 1'b1;
            end
        end
    end

    // Window 0 is paged even for ROM, which gives ROM banking for free.
    assign phys_addr_o = {page_q[addr_i[15:14]], addr_i[WINDOW_BITS-1:0]};

    always_comb begin
        case (target)
            T_ROM:   wait_load = WAIT_W'(ROM_WAIT);
            T_IO:    wait_load = WAIT_W'(IO_WAIT);
            T_UART:  wait_load = WAIT_W'(UART_WAIT);
            default: wait_load = '0;
        endcase
    end

    z80_wait_gen #(
        .CNT_W (WAIT_W)
    ) u_wait_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req    (io_req | mem_req),
        .load   (wait_load),
        .wait_n (wait_n)
    );

    always_comb begin
        data_o = '0;
        if (io_req && !rd_n) begin
            if (is_page) begin
                data_o = 8'(page_q[port[1:0]]);
            end else if (port == STATUS) begin
                data_o = {7'b0, bad_bank_q};
            end else if (port == CTRL) begin
                data_o = {7'b0, rom_dis_q};
            end else if (port == BANK) begin
                data_o = io_bank_q;
            end
        end
    end

    assign wr_act = io_req && !wr_n && dec_cs;
    assign wr_stb = wr_act && !wr_act_q;
    assign st_rd  = io_req && !rd_n && (port == STATUS);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                page_q[i] <= PAGE_W'(i);
            end
            rom_dis_q  <= 1'b0;
            bad_bank_q <= 1'b0;
            io_bank_q  <= '0;
            wr_act_q   <= 1'b0;
            st_rd_q    <= 1'b0;
        end else begin
            wr_act_q <= wr_act;
            st_rd_q  <= st_rd;
            if (wr_stb) begin
                if (is_page) begin
                    page_q[port[1:0]] <= PAGE_W'(data_i);
                end else if (port == CTRL) begin
                    rom_dis_q <= data_i[0];
                end else if (port == BANK) begin
                    io_bank_q <= data_i;
                end
            end
            // Status clears when a read of it completes; a new fault wins.
            if (io_req && target == T_NONE) begin
                bad_bank_q <= 1'b1;
            end else if (st_rd_q && !st_rd) begin
                bad_bank_q <= 1'b0;
            end
        end
    end

endmodule
